// File: rtl/ghost_dir_gen.sv
// Ghost direction generator: LFSR-driven legal direction picker with frame-based hold.
// Define GHOST_NOREV_EN to forbid reversal unless it is the only free direction.
module ghost_dir_gen #(
   parameter int unsigned START_FRAMES = 60,
   parameter int unsigned HOLD_FRAMES  = 32,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       frame_clk,
   input  logic       restart,
   input  logic [4:0] mapL,
   input  logic [4:0] mapR,
   input  logic [4:0] mapB,
   input  logic [4:0] mapT,
   output logic [7:0] randomkeycode,
   output logic       dir_valid
);

   typedef enum logic [1:0] {S_WAIT, S_PICK, S_HOLD} state_t;

`ifdef GHOST_NOREV_EN
   localparam logic [7:0] LAST_TRY = 8'd4;
`else
   localparam logic [7:0] LAST_TRY = 8'd3;
`endif

   function automatic logic [1:0] rev_dir(input logic [1:0] d);
      return {d[1], ~d[0]};
   endfunction

   function automatic logic [7:0] dir_code(input logic [1:0] d);
      case (d)
         2'd0:    return 8'h04;
         2'd1:    return 8'h07;
         2'd2:    return 8'h16;
         default: return 8'h1A;
      endcase
   endfunction

   function automatic logic [4:0] map_at(input logic [1:0] d, input logic [4:0] l,
                                         input logic [4:0] r, input logic [4:0] b,
                                         input logic [4:0] t);
      case (d)
         2'd0:    return l;
         2'd1:    return r;
         2'd2:    return b;
         default: return t;
      endcase
   endfunction

   state_t      state, state_nxt;
   logic [15:0] lfsr;
   logic        fsync_p0, fsync_p1, fsync_p2;
   logic        frame_tick;
   logic [7:0]  hold_cnt;
   logic [7:0]  try_cnt;
   logic [1:0]  cur_dir;
   logic [1:0]  pick_start;
   logic [1:0]  cand;
   logic        cand_ok;
   logic        cur_blocked;
   logic        enter_pick, commit, give_up, count_tick;

   // frame_clk crosses into Clk through two flops; third flop forms the edge detect
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         fsync_p0 <= 1'b0;
         fsync_p1 <= 1'b0;
         fsync_p2 <= 1'b0;
      end else begin
         fsync_p0 <= frame_clk;
         fsync_p1 <= fsync_p0;
         fsync_p2 <= fsync_p1;
      end
   end

   assign frame_tick = fsync_p1 & ~fsync_p2;

   // Free-running; restart deliberately leaves it alone
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) lfsr <= LFSR_SEED;
      else          lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end

`ifdef GHOST_NOREV_EN
   logic pass2;
   assign pass2   = (try_cnt == 8'd4);
   assign cand    = pass2 ? rev_dir(cur_dir) : pick_start + try_cnt[1:0];
   assign cand_ok = (map_at(cand, mapL, mapR, mapB, mapT) == 5'd0) &&
                    (pass2 || (cand != rev_dir(cur_dir)));
`else
   assign cand    = pick_start + try_cnt[1:0];
   assign cand_ok = (map_at(cand, mapL, mapR, mapB, mapT) == 5'd0);
`endif

   assign cur_blocked = dir_valid && (map_at(cur_dir, mapL, mapR, mapB, mapT) != 5'd0);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) state <= S_WAIT;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_WAIT:  if (frame_tick && (hold_cnt <= 8'd1)) state_nxt = S_PICK;
         S_PICK:  if (cand_ok || (try_cnt >= LAST_TRY)) state_nxt = S_HOLD;
         S_HOLD:  if (frame_tick && (cur_blocked || (hold_cnt <= 8'd1))) state_nxt = S_PICK;
         default: state_nxt = S_WAIT;
      endcase
      if (restart) state_nxt = S_WAIT;
   end

   always_comb begin
      enter_pick = 1'b0;
      commit     = 1'b0;
      give_up    = 1'b0;
      count_tick = 1'b0;
      case (state)
         S_WAIT, S_HOLD: begin
            count_tick = frame_tick;
            enter_pick = (state_nxt == S_PICK);
         end
         S_PICK: begin
            commit  = cand_ok;
            give_up = !cand_ok && (try_cnt >= LAST_TRY);
         end
         default: ;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (enter_pick) pick_start <= lfsr[1:0];
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         hold_cnt      <= 8'(START_FRAMES);
         cur_dir       <= 2'd3;
         try_cnt       <= 8'd0;
         randomkeycode <= 8'h00;
         dir_valid     <= 1'b0;
      end else if (restart) begin
         hold_cnt      <= 8'(START_FRAMES);
         cur_dir       <= 2'd3;
         try_cnt       <= 8'd0;
         randomkeycode <= 8'h00;
         dir_valid     <= 1'b0;
      end else begin
         if (count_tick) hold_cnt <= hold_cnt - 8'd1;
         if (enter_pick)          try_cnt <= 8'd0;
         else if (state == S_PICK) try_cnt <= try_cnt + 8'd1;
         if (commit) begin
            randomkeycode <= dir_code(cand);
            dir_valid     <= 1'b1;
            cur_dir       <= cand;
            hold_cnt      <= 8'(HOLD_FRAMES);
         end else if (give_up) begin
            randomkeycode <= 8'h00;
            dir_valid     <= 1'b0;
            hold_cnt      <= 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_ghost_dir_gen.sv
// Scoreboard bench for ghost_dir_gen: stimulus queues expected output changes, a monitor pops them.
module tb_ghost_dir_gen;

   logic       Clk;
   logic       Reset_n;
   logic       frame_clk;
   logic       restart;
   logic [4:0] mapL, mapR, mapB, mapT;
   logic [7:0] randomkeycode;
   logic       dir_valid;

   ghost_dir_gen dut (
      .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .restart(restart),
      .mapL(mapL), .mapR(mapR), .mapB(mapB), .mapT(mapT),
      .randomkeycode(randomkeycode), .dir_valid(dir_valid)
   );

`ifdef GHOST_NOREV_EN
   localparam int REV_MIN  = 8;
   localparam int REV_MAX  = 8;
   localparam int FAIL_LAT = 8;
`else
   localparam int REV_MIN  = 4;
   localparam int REV_MAX  = 7;
   localparam int FAIL_LAT = 7;
`endif

   typedef struct {
      string      nm;
      logic [7:0] key;
      logic       vld;
      int         t0;
      int         lmin;
      int         lmax;
   } exp_t;

   exp_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   bit   mon_en   = 0;

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: got no end of test, required finish before 100us");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string nm, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
      end
   endtask

   task automatic push_exp(input string nm, input logic [7:0] k, input logic v,
                           input int lmin, input int lmax);
      exp_t e;
      e.nm = nm; e.key = k; e.vld = v; e.t0 = cyc; e.lmin = lmin; e.lmax = lmax;
      sb_q.push_back(e);
   endtask

   // Monitor: every output change must match the head of the scoreboard
   initial begin
      exp_t e;
      int   lat;
      wait (mon_en);
      forever begin
         @(randomkeycode or dir_valid);
         #1;
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_change: got key 0x%0h vld %0d, required no change",
                     randomkeycode, dir_valid);
         end else begin
            e   = sb_q.pop_front();
            lat = cyc - e.t0;
            chk({e.nm, "_key"}, int'(randomkeycode), int'(e.key));
            chk({e.nm, "_vld"}, int'(dir_valid), int'(e.vld));
            checks++;
            if (lat < e.lmin || lat > e.lmax) begin
               failures++;
               $display("FAIL %s_lat: got %0d clk, required %0d..%0d clk", e.nm, lat, e.lmin, e.lmax);
            end
         end
      end
   end

   task automatic set_maps(input logic [4:0] l, input logic [4:0] r,
                           input logic [4:0] b, input logic [4:0] t);
      @(negedge Clk);
      mapL = l; mapR = r; mapB = b; mapT = t;
   endtask

   // One frame pulse; an expectation, if any, is timestamped at the frame_clk rise
   task automatic issue_tick(input bit chg, input string nm, input logic [7:0] k,
                             input logic v, input int lmin, input int lmax);
      @(posedge Clk); #2;
      if (chg) push_exp(nm, k, v, lmin, lmax);
      frame_clk = 1'b1;
      repeat (4) @(posedge Clk);
      #2 frame_clk = 1'b0;
      repeat (4) @(posedge Clk);
   endtask

   task automatic quiet_ticks(input int n);
      for (int i = 0; i < n; i++) issue_tick(1'b0, "", 8'h00, 1'b0, 0, 0);
   endtask

   task automatic drain(input string nm);
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 40) begin
         @(posedge Clk);
         n++;
      end
      #2;
      if (sb_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout: got %0d pending change(s), required 0", nm, sb_q.size());
         sb_q.delete();
      end
   endtask

   initial begin
      Reset_n = 1'b0; frame_clk = 1'b0; restart = 1'b0;
      mapL = 5'h00; mapR = 5'h00; mapB = 5'h00; mapT = 5'h00;
      repeat (3) @(posedge Clk);
      #2;
      chk("reset_key", int'(randomkeycode), 8'h00);
      chk("reset_vld", int'(dir_valid), 0);
      Reset_n = 1'b1;
      mon_en  = 1'b1;

      // Start delay: only R free, so the first pick is R whatever the LFSR holds
      set_maps(5'h1F, 5'h00, 5'h1F, 5'h1F);
      quiet_ticks(59);
      chk("wait59_key", int'(randomkeycode), 8'h00);
      chk("wait59_vld", int'(dir_valid), 0);
      issue_tick(1'b1, "start_R", 8'h07, 1'b1, 4, 7);
      drain("start_R");

      // R blocked, only L (its reverse) free
      set_maps(5'h00, 5'h1F, 5'h1F, 5'h1F);
      issue_tick(1'b1, "rev_L", 8'h04, 1'b1, REV_MIN, REV_MAX);
      drain("rev_L");

      // Hold L for 31 ticks, then only R free at expiry
      quiet_ticks(31);
      chk("hold31_key", int'(randomkeycode), 8'h04);
      set_maps(5'h1F, 5'h00, 5'h1F, 5'h1F);
      issue_tick(1'b1, "expiry_R", 8'h07, 1'b1, REV_MIN, REV_MAX);
      drain("expiry_R");

      // Everything blocked, then T opens
      set_maps(5'h1F, 5'h1F, 5'h1F, 5'h1F);
      issue_tick(1'b1, "all_blocked", 8'h00, 1'b0, FAIL_LAT, FAIL_LAT);
      drain("all_blocked");
      set_maps(5'h1F, 5'h1F, 5'h1F, 5'h00);
      issue_tick(1'b1, "reopen_U", 8'h1A, 1'b1, 4, 7);
      drain("reopen_U");

      // Go to D (reverse of U), then block D at tick 10 of its hold
      set_maps(5'h1F, 5'h1F, 5'h00, 5'h1F);
      issue_tick(1'b1, "rev_D", 8'h16, 1'b1, REV_MIN, REV_MAX);
      drain("rev_D");
      quiet_ticks(9);
      chk("hold9_key", int'(randomkeycode), 8'h16);
      set_maps(5'h00, 5'h1F, 5'h03, 5'h1F);
      issue_tick(1'b1, "blocked_exit", 8'h04, 1'b1, 4, 7);
      drain("blocked_exit");

      // restart coincident with a frame_tick that would otherwise re-pick to R
      set_maps(5'h1F, 5'h00, 5'h1F, 5'h1F);
      @(posedge Clk); #2;
      push_exp("restart", 8'h00, 1'b0, 3, 3);
      frame_clk = 1'b1;
      @(posedge Clk); @(posedge Clk); #2;
      restart = 1'b1;
      @(posedge Clk); #2;
      restart = 1'b0;
      @(posedge Clk); #2;
      frame_clk = 1'b0;
      repeat (4) @(posedge Clk);
      drain("restart");
      quiet_ticks(59);
      chk("rst_wait59_key", int'(randomkeycode), 8'h00);
      issue_tick(1'b1, "restart_R", 8'h07, 1'b1, 4, 7);
      drain("restart_R");

      // Asynchronous reset mid-cycle while holding R
      @(posedge Clk); #5;
      push_exp("async_reset", 8'h00, 1'b0, 0, 0);
      Reset_n = 1'b0;
      #2;
      chk("async_key", int'(randomkeycode), 8'h00);
      chk("async_vld", int'(dir_valid), 0);
      @(posedge Clk); #2;
      Reset_n = 1'b1;
      drain("async_reset");
      quiet_ticks(3);
      chk("post_reset_key", int'(randomkeycode), 8'h00);

      chk("scoreboard_empty", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
